// File: rtl/fir_capture_buffer.sv
// Captures DEPTH consecutive FIR output samples on start, then streams them back over a valid/ready port.
// Optional magnitude trigger (ARMED state) is built only when CAPT_TRIG_EN is defined.
module fir_capture_buffer #(
  parameter int WD    = 24,
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [WD-1:0]            data_in_i,
  input  logic                     sample_en_i,
  input  logic                     start_i,
  input  logic                     clear_i,
  input  logic [WD-1:0]            threshold_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [WD-1:0]            rd_data_o,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic                     rd_last_o
);

  localparam int AW = $clog2(DEPTH);

  // state | meaning
  // IDLE  | waiting for start
  // ARMED | waiting for |data_in| > threshold (CAPT_TRIG_EN only)
  // CAPT  | writing strobed samples into memory
  // READ  | streaming memory contents out
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_READ  = 2'd3;

  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_last_q, s1_last_d;
  logic [WD-1:0] s1_data_q;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic [WD-1:0] rd_data_q, rd_data_d;
  logic          done_q, done_d;

  logic [WD-1:0] mem [DEPTH];
  logic          we;
  logic          issue;
  logic          out_load;
  logic          accept;

`ifdef CAPT_TRIG_EN
  logic [WD:0] data_sx;
  logic [WD:0] mag;
  logic        trig;
  // One extra bit so that the most negative sample has a representable magnitude.
  assign data_sx = {data_in_i[WD-1], data_in_i};
  assign mag     = data_in_i[WD-1] ? (~data_sx + 1'b1) : data_sx;
  assign trig    = sample_en_i && (mag > {1'b0, threshold_i});
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold_i;
`endif

  // Two-stage read pipe: s1 is the RAM output, rd_* the output register; s1 refills while rd drains.
  assign accept   = rd_valid_q & rd_ready_i;
  assign out_load = s1_valid_q & (~rd_valid_q | rd_ready_i);
  assign issue    = (state_q == S_READ) && (rd_ptr_q != FULL) && (~s1_valid_q | out_load);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    rd_ptr_d   = rd_ptr_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    we         = 1'b0;

    if (issue) begin
      s1_valid_d = 1'b1;
      s1_last_d  = (rd_ptr_q[AW-1:0] == LAST_ADDR);
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end else if (out_load) begin
      s1_valid_d = 1'b0;
    end

    if (out_load) begin
      rd_valid_d = 1'b1;
      rd_data_d  = s1_data_q;
      rd_last_d  = s1_last_q;
    end else if (accept) begin
      rd_valid_d = 1'b0;
    end

    if (accept) level_d = level_q - 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
`ifdef CAPT_TRIG_EN
          state_d = S_ARMED;
`else
          state_d = S_CAPT;
`endif
          wr_ptr_d = '0;
          level_d  = '0;
        end
      end
`ifdef CAPT_TRIG_EN
      S_ARMED: begin
        if (trig) begin
          we       = 1'b1;
          wr_ptr_d = AW'(1);
          level_d  = (AW+1)'(1);
          state_d  = S_CAPT;
        end
      end
`endif
      S_CAPT: begin
        if (sample_en_i) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          level_d  = level_q + 1'b1;
          if (wr_ptr_q == LAST_ADDR) begin
            state_d  = S_READ;
            done_d   = 1'b1;
            rd_ptr_d = '0;
          end
        end
      end
      S_READ: begin
        if (accept && rd_last_q) begin
          state_d   = S_IDLE;
          rd_last_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_i) begin
      state_d    = S_IDLE;
      wr_ptr_d   = '0;
      level_d    = '0;
      rd_ptr_d   = '0;
      s1_valid_d = 1'b0;
      s1_last_d  = 1'b0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      rd_data_d  = '0;
      done_d     = 1'b0;
      we         = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      rd_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      rd_ptr_q   <= rd_ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
    end
  end

  // Sample storage and its registered read port carry no reset.
  always_ff @(posedge clk_i) begin
    if (we) mem[wr_ptr_q] <= data_in_i;
    if (issue) s1_data_q <= mem[rd_ptr_q[AW-1:0]];
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign level_o    = level_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_last_q;

endmodule

// File: tb/tb_fir_capture_buffer.sv
// Randomized bench for fir_capture_buffer (DEPTH=8) against a queue-based capture/readout model.
module tb_fir_capture_buffer;

  localparam int WD    = 24;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [WD-1:0] data_in = '0;
  logic          sample_en = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [WD-1:0] threshold = '0;
  logic          busy, done, rd_valid, rd_last;
  logic          rd_ready = 1'b0;
  logic [3:0]    level;
  logic [WD-1:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WD-1:0] exp_q[$];
  logic [WD-1:0] got_q[$];
  logic          last_q[$];
  int stall_err, rlvl_err, first_valid, last_acc, rd_timeout;

  always #5 clk = ~clk;

  fir_capture_buffer #(.WD(WD), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .data_in_i(data_in), .sample_en_i(sample_en),
    .start_i(start), .clear_i(clear), .threshold_i(threshold), .busy_o(busy), .done_o(done),
    .level_o(level), .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_last_o(rd_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // en_mode: 0 always strobed, 1 alternating starting low, 2 random strobe
  task automatic do_capture(input int en_mode, input bit ramp, output int cycles,
                            output int lvl_err, output int done_seen);
    logic en;
    exp_q.delete();
    cycles = 0; lvl_err = 0; done_seen = 0;
    while (exp_q.size() < DEPTH && cycles < 200) begin
      en = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? (cycles % 2 == 1) : 1'($urandom);
      data_in   = ramp ? WD'(exp_q.size() + 1) : WD'($urandom);
      sample_en = en;
      step();
      cycles++;
      if (en) exp_q.push_back(data_in);
      if (level != 4'(exp_q.size())) lvl_err++;
      if (done) done_seen++;
    end
    sample_en = 1'b0;
  endtask

  // rdy_mode: 0 always ready, 1 ready every third cycle, 2 random ready
  task automatic drain(input int rdy_mode, input bit poke_start);
    logic [WD-1:0] held = '0;
    bit stalled = 0;
    bit rdy;
    int cyc = 0;
    int n = 0;
    got_q.delete(); last_q.delete();
    stall_err = 0; rlvl_err = 0; first_valid = -1; last_acc = -1;
    while (n < DEPTH && cyc < 300) begin
      rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 0) : 1'($urandom);
      rd_ready = rdy;
      if (poke_start) start = 1'($urandom);
      if (stalled && (!rd_valid || rd_data !== held)) stall_err++;
      if (rd_valid && first_valid < 0) first_valid = cyc;
      if (rd_valid && rdy) begin
        if (level != 4'(DEPTH - n)) rlvl_err++;
        got_q.push_back(rd_data);
        last_q.push_back(rd_last);
        n++;
        last_acc = cyc;
        stalled = 0;
      end else if (rd_valid) begin
        stalled = 1;
        held = rd_data;
      end
      step();
      cyc++;
    end
    rd_ready = 1'b0;
    start = 1'b0;
    rd_timeout = (n < DEPTH) ? 1 : 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0h want 0", done); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %0h want 0", rd_valid); end
    n_checks++; if (rd_last !== 1'b0) begin n_fail++; $display("FAIL reset_rd_last: got %0h want 0", rd_last); end
    n_checks++; if (rd_data !== 24'h0) begin n_fail++; $display("FAIL reset_rd_data: got %06h want 000000", rd_data); end
  endtask

  task automatic test_ramp();
    int cycles, lerr, dseen;
    do_start();
    do_capture(0, 1, cycles, lerr, dseen);
    n_checks++; if (cycles != DEPTH) begin n_fail++; $display("FAIL ramp_fill_cycles: got %0d want %0d", cycles, DEPTH); end
    n_checks++; if (done !== 1'b1 || dseen != 1) begin n_fail++; $display("FAIL ramp_done: done=%0h pulses=%0d want 1/1", done, dseen); end
    n_checks++; if (lerr != 0) begin n_fail++; $display("FAIL ramp_capture_level: got %0d bad cycles want 0", lerr); end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ramp_done_pulse: got %0h want 0", done); end
    drain(0, 0);
    n_checks++; if (rd_timeout != 0) begin n_fail++; $display("FAIL ramp_read_timeout: got %0d samples want %0d", got_q.size(), DEPTH); end
    // Latency is measured from one cycle later here because of the extra step above.
    n_checks++; if (first_valid != 1) begin n_fail++; $display("FAIL ramp_latency: got %0d want 1", first_valid); end
    n_checks++; if (last_acc != DEPTH) begin n_fail++; $display("FAIL ramp_throughput: last accept %0d want %0d", last_acc, DEPTH); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== WD'(i + 1)) begin n_fail++; $display("FAIL ramp_data[%0d]: got %06h want %06h", i, got_q[i], i + 1); end
      n_checks++; if (last_q[i] !== (i == DEPTH - 1)) begin n_fail++; $display("FAIL ramp_last[%0d]: got %0h want %0h", i, last_q[i], i == DEPTH - 1); end
    end
    n_checks++; if (busy !== 1'b0 || rd_valid !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL ramp_end_idle: busy=%0h valid=%0h level=%0d want 0/0/0", busy, rd_valid, level); end
  endtask

  task automatic test_backpressure();
    int cycles, lerr, dseen;
    for (int mode = 1; mode <= 2; mode++) begin
      do_start();
      do_capture(0, 0, cycles, lerr, dseen);
      drain(mode, 0);
      n_checks++; if (rd_timeout != 0) begin n_fail++; $display("FAIL bp_timeout: mode %0d got %0d samples want %0d", mode, got_q.size(), DEPTH); end
      n_checks++; if (first_valid != 2) begin n_fail++; $display("FAIL bp_latency: mode %0d got %0d want 2", mode, first_valid); end
      n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stall_stable: mode %0d got %0d changes want 0", mode, stall_err); end
      n_checks++; if (rlvl_err != 0) begin n_fail++; $display("FAIL bp_level: mode %0d got %0d bad accepts want 0", mode, rlvl_err); end
      for (int i = 0; i < got_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i] || last_q[i] !== (i == DEPTH - 1)) begin n_fail++; $display("FAIL bp_data[%0d]: got %06h/%0h want %06h/%0h", i, got_q[i], last_q[i], exp_q[i], i == DEPTH - 1); end
      end
      n_checks++; if (busy !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL bp_end_idle: busy=%0h level=%0d want 0/0", busy, level); end
    end
  endtask

  task automatic test_sample_en();
    int cycles, lerr, dseen;
    do_start();
    do_capture(1, 0, cycles, lerr, dseen);
    n_checks++; if (cycles != 2 * DEPTH) begin n_fail++; $display("FAIL sen_fill_cycles: got %0d want %0d", cycles, 2 * DEPTH); end
    n_checks++; if (lerr != 0 || dseen != 1) begin n_fail++; $display("FAIL sen_level_done: lvl errs %0d done pulses %0d want 0/1", lerr, dseen); end
    drain(2, 0);
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sen_data[%0d]: got %06h want %06h", i, got_q[i], exp_q[i]); end
    end
    do_start();
    do_capture(2, 0, cycles, lerr, dseen);
    n_checks++; if (lerr != 0 || dseen != 1) begin n_fail++; $display("FAIL sen_rand_level: lvl errs %0d done pulses %0d want 0/1", lerr, dseen); end
    drain(0, 0);
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sen_rand_data[%0d]: got %06h want %06h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_during_read();
    int cycles, lerr, dseen;
    do_start();
    do_capture(0, 0, cycles, lerr, dseen);
    drain(2, 1);
    n_checks++; if (rd_timeout != 0 || stall_err != 0) begin n_fail++; $display("FAIL sdr_stream: timeout=%0d stall errs=%0d want 0/0", rd_timeout, stall_err); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sdr_data[%0d]: got %06h want %06h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sdr_end_idle: busy=%0h want 0", busy); end
  endtask

  task automatic test_clear();
    int cycles, lerr, dseen;
    do_start();
    sample_en = 1'b1;
    repeat (3) begin
      data_in = WD'($urandom);
      step();
    end
    sample_en = 1'b0;
    n_checks++; if (level !== 4'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL clr_pre_level: level=%0d busy=%0h want 3/1", level, busy); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++; if (busy !== 1'b0 || level !== 4'd0 || done !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL clr_capture: busy=%0h level=%0d done=%0h valid=%0h want 0/0/0/0", busy, level, done, rd_valid); end
    start = 1'b1; clear = 1'b1;
    step();
    start = 1'b0; clear = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_with_start: busy=%0h want 0", busy); end
    do_start();
    do_capture(0, 0, cycles, lerr, dseen);
    drain(0, 0);
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clr_refill_data[%0d]: got %06h want %06h", i, got_q[i], exp_q[i]); end
    end
    do_start();
    do_capture(0, 0, cycles, lerr, dseen);
    repeat (3) step();
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL clr_read_setup: valid=%0h want 1", rd_valid); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++; if (busy !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 24'h0 || level !== 4'd0) begin n_fail++; $display("FAIL clr_read: busy=%0h valid=%0h data=%06h level=%0d want 0/0/0/0", busy, rd_valid, rd_data, level); end
  endtask

  task automatic test_async_reset();
    int cycles, lerr, dseen;
    do_start();
    do_capture(0, 0, cycles, lerr, dseen);
    rd_ready = 1'b1;
    repeat (4) step();
    rd_ready = 1'b0;
    n_checks++; if (rd_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL arst_setup: valid=%0h busy=%0h want 1/1", rd_valid, busy); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || rd_valid !== 1'b0 || level !== 4'd0 || rd_data !== 24'h0) begin n_fail++; $display("FAIL arst_immediate: busy=%0h valid=%0h level=%0d data=%06h want 0/0/0/0", busy, rd_valid, level, rd_data); end
    @(posedge clk);
    #2 reset_n = 1'b1;
    rd_ready = 1'b1;
    repeat (3) step();
    rd_ready = 1'b0;
    n_checks++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL arst_no_resume: busy=%0h valid=%0h want 0/0", busy, rd_valid); end
  endtask

`ifdef CAPT_TRIG_EN
  task automatic test_trigger();
    logic [WD-1:0] stim[$];
    logic [WD-1:0] d;
    int v, mag, cyc;
    bit trig;
    threshold = 24'h000100;
    for (int run = 0; run < 2; run++) begin
      if (run == 0) stim = '{24'h000010, 24'hFFFFF0, 24'hFFFE00};
      else          stim = '{24'h000001, 24'h800000};
      do_start();
      n_checks++; if (busy !== 1'b1 || level !== 4'd0) begin n_fail++; $display("FAIL trig_armed: run %0d busy=%0h level=%0d want 1/0", run, busy, level); end
      exp_q.delete();
      trig = 0; cyc = 0;
      while (exp_q.size() < DEPTH && cyc < 100) begin
        d = (cyc < stim.size()) ? stim[cyc] : WD'($urandom);
        data_in = d; sample_en = 1'b1;
        step();
        cyc++;
        if (!trig) begin
          v = int'($signed(d));
          mag = (v < 0) ? -v : v;
          if (mag > int'(threshold)) trig = 1;
        end
        if (trig) exp_q.push_back(d);
        if (!trig) begin
          n_checks++; if (level !== 4'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL trig_wait: run %0d level=%0d busy=%0h want 0/1", run, level, busy); end
        end
      end
      sample_en = 1'b0;
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL trig_done: run %0d got %0h want 1", run, done); end
      drain(0, 0);
      for (int i = 0; i < got_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL trig_data[%0d]: run %0d got %06h want %06h", i, run, got_q[i], exp_q[i]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef CAPT_TRIG_EN
    test_trigger();
`else
    test_ramp();
    test_backpressure();
    test_sample_en();
    test_start_during_read();
    test_clear();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
